// File: rtl/riscv_pkg.sv
// RV32I opcode constants, immediate format encoding and the opcode-to-format map.
// Shared by the decode stage and its immediate generator.
package riscv_pkg;

    localparam int REG_AW = 5;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    function automatic imm_fmt_t opcode_fmt(input logic [6:0] opcode);
        imm_fmt_t fmt;
        case (opcode)
            OP_IMM, LOAD, JALR: fmt = IMM_I;
            STORE:              fmt = IMM_S;
            BRANCH:             fmt = IMM_B;
            LUI, AUIPC:         fmt = IMM_U;
            JAL:                fmt = IMM_J;
            default:            fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Sign-extended immediate for an RV32I instruction; purely combinational.
// R-type and illegal opcodes map to IMM_NONE and produce zero.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  imm_fmt_t        fmt,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        unique case (fmt)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed cast so a wider datapath still sign-extends.
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode: register read addressing, RAW busy scoreboard, ID/EX register.
// One cycle accept-to-out_valid; stalls on hazards or while ID/EX is held.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [XLEN-1:0]   out_imm,
    output logic [REG_AW-1:0] out_rd,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_funct3,
    output logic              out_funct7b5,
    output logic              out_illegal
);

    logic [6:0]        opcode;
    logic [REG_AW-1:0] rd;
    imm_fmt_t          fmt;
    logic              legal, uses_rs1, uses_rs2, writes_rd, hazard, accept;
    logic [XLEN-1:0]   imm;
    logic [NREG-1:0]   busy, busy_nxt;

    assign opcode   = in_instr[6:0];
    assign rd       = in_instr[11:7];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign fmt      = opcode_fmt(opcode);

    always_comb begin
        legal     = 1'b0;
        writes_rd = 1'b0;
        uses_rs2  = 1'b0;
        case (opcode)
            OP:                                    begin legal = 1'b1; writes_rd = 1'b1; uses_rs2 = 1'b1; end
            OP_IMM, LOAD, JALR, LUI, AUIPC, JAL:   begin legal = 1'b1; writes_rd = 1'b1; end
            STORE, BRANCH:                         begin legal = 1'b1; uses_rs2 = 1'b1; end
            default:                               ;
        endcase
    end

    assign uses_rs1 = legal && (fmt != IMM_U) && (fmt != IMM_J);

    // x0 can never be busy, but guard it anyway so a stray set cannot deadlock.
    assign hazard = (uses_rs1 && (rs1_addr != '0) && busy[rs1_addr]) ||
                    (uses_rs2 && (rs2_addr != '0) && busy[rs2_addr]);

    assign in_ready = !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (fmt),
        .imm   (imm)
    );

    // Clear first, then set, so a same-index set wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_valid && (wb_addr != '0))
            busy_nxt[wb_addr] = 1'b0;
        if (accept && writes_rd && (rd != '0))
            busy_nxt[rd] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy         <= '0;
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_rs1_val  <= '0;
            out_rs2_val  <= '0;
            out_imm      <= '0;
            out_rd       <= '0;
            out_opcode   <= '0;
            out_funct3   <= '0;
            out_funct7b5 <= 1'b0;
            out_illegal  <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (accept) begin
                out_valid    <= 1'b1;
                out_pc       <= in_pc;
                out_rs1_val  <= rs1_data;
                out_rs2_val  <= rs2_data;
                out_imm      <= imm;
                out_rd       <= writes_rd ? rd : '0;
                out_opcode   <= opcode;
                out_funct3   <= in_instr[14:12];
                out_funct7b5 <= in_instr[30];
                out_illegal  <= !legal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
